sipo_rx_ctrl: RTL

- Frame controller for a serial-in/parallel-out receive path.
- Qualifies and counts incoming serial bits and drives a shift-enabled SIPO register.
- Captures each completed WIDTH-bit word into an output holding register.
- Hands words downstream over a valid/ready handshake, with restart, overrun and (optional) parity error reporting.

---
 rtl/sipo_rx_pkg.sv | 20 ++
 rtl/sipo_shift_en.sv | 33 +++
 rtl/sipo_rx_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receive path.
// Contents: FSM state type, default word width, parity helper.
package sipo_rx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Returns 1 when v has an odd number of ones (even-parity violation).
    // Callers zero-extend, which leaves the result unchanged.
    function automatic logic odd_ones(input logic [MAX_WIDTH:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit shift register; new bits enter at [0] and move toward the MSB.
// Ports:
//   clk        clock
//   clr        synchronous clear (highest priority)
//   load_first restart: register becomes {0..0, din}
//   shift_en   shift din in at [0]
//   din        serial bit
//   q          register contents
module sipo_shift_en
    import sipo_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_first,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Restart wins over shift so a new frame never inherits stale bits.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load_first) begin
            q <= WIDTH'(din);
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller for a serial-in/parallel-out receive path: qualifies and
// counts serial bits, drives the shifter, captures completed words into a
// holding register and offers them over a valid/ready handshake.
// Optional feature macro: PARITY_CHECK_EN (one even-parity bit after the data).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ser_in/ser_valid         serial bit and its qualifier
//   frame_start              current bit is the first of a frame
//   par_out/par_valid/par_ready  word output handshake
//   busy                     frame in progress
//   bit_cnt                  data bits accepted in the current frame
//   overrun/frame_err/parity_err one-cycle status pulses
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err
);

    state_t           state;
    logic [WIDTH-1:0] sr_q;
    logic             restart_c;
    logic             shift_c;
    logic             complete_c;
    logic [WIDTH-1:0] word_c;

    sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
        .clk        (clk),
        .clr        (rst),
        .load_first (restart_c),
        .shift_en   (shift_c),
        .din        (ser_in),
        .q          (sr_q)
    );

    // A frame_start bit always restarts the shifter, whatever the state.
    assign restart_c = ser_valid & frame_start;
    assign shift_c   = ser_valid & ~frame_start & (state == SHIFT);

`ifdef PARITY_CHECK_EN
    logic parity_bad_c;
    logic parity_err_q;

    // Word is already complete in the shifter while the parity bit arrives.
    assign word_c       = sr_q;
    assign parity_bad_c = odd_ones((MAX_WIDTH + 1)'({sr_q, ser_in}));
    assign complete_c   = ser_valid & ~frame_start & (state == PARITY) & ~parity_bad_c;
    assign parity_err   = parity_err_q;
`else
    logic unused_msb_c;

    // Last data bit is folded in directly so the word is ready on its own edge.
    assign word_c       = {sr_q[WIDTH-2:0], ser_in};
    assign unused_msb_c = sr_q[WIDTH-1];
    assign complete_c   = ser_valid & ~frame_start & (state == SHIFT)
                        & (bit_cnt == CNT_W'(WIDTH - 1));
    assign parity_err   = 1'b0;
`endif

    // Controller FSM, bit counter, holding register and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            // Holding register: completion may replace a word being taken.
            if (complete_c) begin
                if (!par_valid || par_ready) begin
                    par_out   <= word_c;
                    par_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (par_valid && par_ready) begin
                par_valid <= 1'b0;
            end

            if (ser_valid) begin
                case (state)
                    IDLE: begin
                        if (frame_start) begin
                            bit_cnt <= CNT_W'(1);
                            state   <= SHIFT;
                            busy    <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (frame_start) begin
                            bit_cnt   <= CNT_W'(1);
                            frame_err <= 1'b1;
                        end else if (bit_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                            bit_cnt <= CNT_W'(WIDTH);
                            state   <= PARITY;
`else
                            bit_cnt <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PARITY: begin
                        if (frame_start) begin
                            bit_cnt   <= CNT_W'(1);
                            frame_err <= 1'b1;
                            state     <= SHIFT;
                        end else begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                            if (parity_bad_c) begin
                                parity_err_q <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
